// File: rtl/divider_pkg.sv
// Shared constants and FSM state type for the restoring divider.
package divider_pkg;

  localparam int unsigned WIDTH_DEFAULT = 128;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/divider_step.sv
// One restoring shift-subtract iteration: shift a dividend bit into the
// partial remainder and subtract the divisor when it fits.
module divider_step
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0]   w_partial;
  logic [WIDTH-1:0] w_diff;

  // The carry bit of the shifted remainder forces a subtract; the low-bit
  // difference is then exact because the result is always below the divisor.
  always_comb begin
    w_partial = {i_rem, i_bit};
    w_diff    = w_partial[WIDTH-1:0] - i_divisor;
    o_qbit    = w_partial[WIDTH] | (w_partial[WIDTH-1:0] >= i_divisor);
    o_rem     = o_qbit ? w_diff : w_partial[WIDTH-1:0];
  end

endmodule

// File: rtl/divider_128bits_version11.sv
// Multi-cycle restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per cycle, with divide-by-zero and overflow detection.
module divider_128bits_version11
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               overflow
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t           r_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_dvs;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dz;
  logic             r_ov;

  logic [WIDTH-1:0] w_rem;
  logic             w_qbit;

  divider_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_lo[WIDTH-1]),
    .i_divisor (r_dvs),
    .o_rem     (w_rem),
    .o_qbit    (w_qbit)
  );

  // r_lo holds unconsumed dividend bits on the left and collects quotient
  // bits on the right; error paths preload it with the final result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_rem       <= '0;
      r_lo        <= '0;
      r_dvs       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quot      <= '0;
      r_remainder <= '0;
      r_dz        <= 1'b0;
      r_ov        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_dvs  <= divisor;
            r_dz   <= 1'b0;
            r_ov   <= 1'b0;
            r_busy <= 1'b1;
            if (divisor == '0) begin
              r_dz    <= 1'b1;
              r_lo    <= '1;
              r_rem   <= dividend[WIDTH-1:0];
              r_state <= DONE;
            end else if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
              r_ov    <= 1'b1;
              r_lo    <= '1;
              r_rem   <= '0;
              r_state <= DONE;
            end else begin
              r_rem   <= dividend[2*WIDTH-1:WIDTH];
              r_lo    <= dividend[WIDTH-1:0];
              r_count <= CW'(WIDTH);
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          r_rem   <= w_rem;
          r_lo    <= {r_lo[WIDTH-2:0], w_qbit};
          r_count <= r_count - 1'b1;
          if (r_count == CW'(1)) r_state <= DONE;
        end
        DONE: begin
          r_done      <= 1'b1;
          r_busy      <= 1'b0;
          r_quot      <= r_lo;
          r_remainder <= r_rem;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dz;
  assign overflow    = r_ov;

endmodule

// File: tb/tb_divider_128bits_version11.sv
// Self-checking bench for divider_128bits_version11 against a wide-arithmetic model.
module tb_divider_128bits_version11;

  localparam int W = 128;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           busy, done, div_by_zero, overflow;
  logic [W-1:0]   quotient, remainder;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  divider_128bits_version11 #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  function automatic logic [W-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference: plain integer division on 2W-bit values.
  task automatic model(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs,
                       output logic [2*W+1:0] res, output int lat);
    logic [2*W-1:0] wide_dvs, wq, wr;
    logic [W-1:0]   hi, lo;
    hi = dvd[2*W-1:W];
    lo = dvd[W-1:0];
    wide_dvs = {{W{1'b0}}, dvs};
    if (dvs == 0) begin
      res = {{W{1'b1}}, lo, 1'b1, 1'b0};
      lat = 1;
    end else if (hi >= dvs) begin
      res = {{W{1'b1}}, {W{1'b0}}, 1'b0, 1'b1};
      lat = 1;
    end else begin
      wq  = dvd / wide_dvs;
      wr  = dvd % wide_dvs;
      res = {wq[W-1:0], wr[W-1:0], 1'b0, 1'b0};
      lat = W + 1;
    end
  endtask

  // Drive one operation and capture {quotient, remainder, dz, ov} at done.
  task automatic run_op(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs,
                        output logic [2*W+1:0] res, output int lat,
                        output logic busy1, output logic busy_at_done,
                        output logic done2);
    @(negedge clk);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy1 = busy;
    lat = 0;
    while (lat < 300) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
    res          = {quotient, remainder, div_by_zero, overflow};
    busy_at_done = busy;
    @(posedge clk); #1;
    done2 = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_vec++; if (quotient !== '0) begin n_err++; $display("FAIL reset_quot got %h want 0", quotient); end
    n_vec++; if (remainder !== '0) begin n_err++; $display("FAIL reset_rem got %h want 0", remainder); end
    n_vec++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset_dz got %b want 0", div_by_zero); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ov got %b want 0", overflow); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [2*W-1:0] dvd[4];
    logic [W-1:0]   dvs[4];
    logic [2*W-1:0] a, b;
    logic [2*W+1:0] got, exp;
    int             lat, exp_lat;
    logic           b1, bd, d2;
    a = 256'h5829EC10;
    b = 256'h123BBBCF00000000;
    dvd[0] = a * b;
    dvs[0] = 128'h123BBBCF00000000;
    a = 256'h3489BE8F00000000;
    b = 256'hFFFFFFFF;
    dvd[1] = a * b + 256'd5;
    dvs[1] = 128'hFFFFFFFF;
    dvd[2] = 256'hAB5BAFFF00000FD3;
    dvs[2] = '0;
    dvd[3] = {128'd1, 128'd0};
    dvs[3] = 128'd1;
    for (int i = 0; i < 4; i++) begin
      model(dvd[i], dvs[i], exp, exp_lat);
      run_op(dvd[i], dvs[i], got, lat, b1, bd, d2);
      n_vec++; if (got !== exp) begin n_err++; $display("FAIL directed%0d_result got %h want %h", i, got, exp); end
      n_vec++; if (lat !== exp_lat) begin n_err++; $display("FAIL directed%0d_latency got %0d want %0d", i, lat, exp_lat); end
      n_vec++; if (b1 !== 1'b1) begin n_err++; $display("FAIL directed%0d_busy got %b want 1", i, b1); end
      n_vec++; if (bd !== 1'b0) begin n_err++; $display("FAIL directed%0d_busy_at_done got %b want 0", i, bd); end
      n_vec++; if (d2 !== 1'b0) begin n_err++; $display("FAIL directed%0d_done_width got %b want 0", i, d2); end
    end
    // spot-check the literal expectations from the model
    model(dvd[0], dvs[0], exp, exp_lat);
    n_vec++; if (exp[2*W+1:W+2] !== 128'h5829EC10) begin n_err++; $display("FAIL model_exact got %h want 5829ec10", exp[2*W+1:W+2]); end
  endtask

  task automatic test_random();
    logic [2*W-1:0] dvd;
    logic [W-1:0]   dvs, hi;
    logic [2*W+1:0] got, exp;
    int             lat, exp_lat, kind;
    logic           b1, bd, d2;
    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 9);
      dvd  = {rand128(), rand128()};
      if (kind == 0) begin
        dvs = '0;
      end else if (kind == 1) begin
        hi = rand128() | {1'b1, {(W-1){1'b0}}};
        dvs = hi >> $urandom_range(0, W-1);
        dvd[2*W-1:W] = hi;
      end else begin
        dvs = rand128() >> $urandom_range(0, W-1);
        if (dvs == 0) dvs = 128'd3;
        hi = dvd[2*W-1:W] % dvs;
        dvd[2*W-1:W] = hi;
      end
      model(dvd, dvs, exp, exp_lat);
      run_op(dvd, dvs, got, lat, b1, bd, d2);
      n_vec++; if (got !== exp) begin n_err++; $display("FAIL random%0d_result got %h want %h", i, got, exp); end
      n_vec++; if (lat !== exp_lat) begin n_err++; $display("FAIL random%0d_latency got %0d want %0d", i, lat, exp_lat); end
      n_vec++; if (d2 !== 1'b0) begin n_err++; $display("FAIL random%0d_done_width got %b want 0", i, d2); end
    end
  endtask

  task automatic test_ignore_start();
    logic [2*W-1:0] dvd;
    logic [W-1:0]   dvs;
    logic [2*W+1:0] exp, got;
    int             lat, exp_lat;
    dvd = {rand128() >> 1, rand128()};
    dvs = {1'b1, rand128() >> 1};
    model(dvd, dvs, exp, exp_lat);
    @(negedge clk);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (lat < 300) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
      if (lat == 50) begin
        start    = 1'b1;
        dividend = {rand128(), rand128()};
        divisor  = '0;
      end else if (lat == 51) begin
        start = 1'b0;
      end
    end
    got = {quotient, remainder, div_by_zero, overflow};
    n_vec++; if (got !== exp) begin n_err++; $display("FAIL ignore_result got %h want %h", got, exp); end
    n_vec++; if (lat !== exp_lat) begin n_err++; $display("FAIL ignore_latency got %0d want %0d", lat, exp_lat); end
  endtask

  task automatic test_reset_mid_run();
    logic [2*W-1:0] dvd;
    logic [W-1:0]   dvs;
    logic [2*W+1:0] exp, got;
    int             lat, exp_lat;
    logic           seen_done;
    dvd = {rand128() >> 2, rand128()};
    dvs = {1'b1, rand128() >> 1};
    @(negedge clk);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen_done = 1'b0;
    for (int c = 1; c < 60; c++) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (seen_done !== 1'b0) begin n_err++; $display("FAIL midreset_early_done got %b want 0", seen_done); end
    got = {quotient, remainder, div_by_zero, overflow};
    n_vec++; if ({busy, done, got} !== '0) begin n_err++; $display("FAIL midreset_outputs got %h want 0", {busy, done, got}); end
    dvd = {rand128() >> 3, rand128()};
    dvs = rand128() | {1'b1, {(W-1){1'b0}}};
    model(dvd, dvs, exp, exp_lat);
    rst_n    = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL midreset_accept got %b want 1", busy); end
    lat = 0;
    while (lat < 300) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
    got = {quotient, remainder, div_by_zero, overflow};
    n_vec++; if (got !== exp) begin n_err++; $display("FAIL midreset_result got %h want %h", got, exp); end
    n_vec++; if (lat !== exp_lat) begin n_err++; $display("FAIL midreset_latency got %0d want %0d", lat, exp_lat); end
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] dvd;
    logic [W-1:0]   dvs;
    logic [2*W+1:0] exp, got;
    int             gap, exp_lat;
    dvd = {rand128() >> 1, rand128()};
    dvs = rand128() | {1'b1, {(W-1){1'b0}}};
    model(dvd, dvs, exp, exp_lat);
    @(negedge clk);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    gap = 0;
    while (gap < 300) begin
      @(posedge clk); #1;
      gap++;
      if (done) break;
    end
    got = {quotient, remainder, div_by_zero, overflow};
    n_vec++; if (got !== exp) begin n_err++; $display("FAIL b2b_first_result got %h want %h", got, exp); end
    gap = 0;
    while (gap < 300) begin
      @(posedge clk); #1;
      gap++;
      if (done) break;
    end
    start = 1'b0;
    got = {quotient, remainder, div_by_zero, overflow};
    n_vec++; if (gap !== 130) begin n_err++; $display("FAIL b2b_spacing got %0d want 130", gap); end
    n_vec++; if (got !== exp) begin n_err++; $display("FAIL b2b_second_result got %h want %h", got, exp); end
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle_after got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/divider_128bits_version11.md
DIVIDER_128BITS_VERSION11 -- requirements
Module: divider_128bits_version11

Interface
REQ-001 Parameter WIDTH, default 128, operand width; dividend is 2*WIDTH bits, quotient and remainder are WIDTH bits each.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  request; sampled only while busy=0.
REQ-005 dividend  input  2*WIDTH  numerator, typically a product from multiplier_128bits_version11.
REQ-006 divisor  input  WIDTH  denominator.
REQ-007 busy  output  1  high from the cycle after an accepted start until done is high.
REQ-008 done  output  1  one-cycle pulse; results valid from that cycle on.
REQ-009 quotient  output  WIDTH  registered quotient.
REQ-010 remainder  output  WIDTH  registered remainder.
REQ-011 div_by_zero  output  1  registered error flag: divisor was zero.
REQ-012 overflow  output  1  registered error flag: quotient does not fit in WIDTH bits.

Function
REQ-013 States SHALL be IDLE, RUN and DONE; the reset state is IDLE.
REQ-014 IDLE with start=1: capture dividend and divisor and clear both error flags.
REQ-015 Error transition: if divisor==0 or dividend[2*WIDTH-1:WIDTH] >= divisor, go directly to DONE; otherwise go to RUN with iteration count = WIDTH.
REQ-016 div_by_zero has priority over overflow; only one of the two flags is set per operation.
REQ-017 RUN: one restoring shift-subtract step per cycle, using a (WIDTH+1)-bit partial remainder so the subtract never loses the carry.
REQ-018 RUN: shift in the next dividend bit, MSB first, and record each quotient bit; after the WIDTH-th step go to DONE.
REQ-019 DONE: assert done for exactly one cycle, then return to IDLE.
REQ-020 Latency: done is high WIDTH+1 cycles after the start-sampling edge for a normal divide, and 1 cycle after it for an error.
REQ-021 Normal result: quotient = floor(dividend/divisor), remainder = dividend mod divisor, exact for all operands.
REQ-022 div_by_zero result: quotient = all ones, remainder = dividend[WIDTH-1:0].
REQ-023 overflow result: quotient = all ones, remainder = 0.
REQ-024 start while busy=1 or in DONE is ignored, with no effect on the running operation.
REQ-025 start held high continuously is accepted again in the IDLE cycle after done, giving back-to-back operations.
REQ-026 Input changes after acceptance do not affect the running operation.
REQ-027 quotient, remainder and the flags hold their values until the next accepted start updates them.

Reset
REQ-028 rst_n=0 at a rising edge forces IDLE and clears busy, done, quotient, remainder, div_by_zero, overflow and the iteration counter to 0.
REQ-029 Reset mid-RUN aborts the operation with no done pulse; start is accepted on the first edge with rst_n=1.

Structure
REQ-030 Shared package divider_pkg holds WIDTH_DEFAULT=128 and the state enum {IDLE, RUN, DONE}.
REQ-031 One sub-module, divider_step: combinational, one restoring iteration (partial remainder and next bit in; new remainder and quotient bit out).
REQ-032 The iteration counter is $clog2(WIDTH+1) bits wide; there is no other multi-cycle datapath.

Verification
REQ-033 Exact divide: dividend=0x5829EC10*0x123BBBCF00000000, divisor=0x123BBBCF00000000 -> quotient=0x5829EC10, remainder=0, done at cycle 129, no flags.
REQ-034 Remainder: dividend=0x3489BE8F00000000*0xFFFFFFFF+5, divisor=0xFFFFFFFF -> quotient=0x3489BE8F00000000, remainder=5.
REQ-035 Divide by zero: divisor=0, dividend=0xAB5BAFFF00000FD3 -> div_by_zero=1, quotient=all ones, remainder=0xAB5BAFFF00000FD3, done 1 cycle after start.
REQ-036 Overflow: dividend[255:128]=divisor=1 -> overflow=1, quotient=all ones, remainder=0, done 1 cycle after start.
REQ-037 Start pulsed at cycle 50 of a RUN, inputs changed -> ignored; the original result is unchanged.
REQ-038 rst_n=0 at cycle 60 of a RUN -> all outputs 0, no done pulse; a new start then completes correctly. Back-to-back starts yield done pulses 130 cycles apart.
